// File: rtl/alu_issue_ctrl_if.sv
// Command, Alu-drive and response bundle between the issue controller and its neighbours.
`timescale 1ns/1ps
interface alu_issue_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_mode;
  logic [1:0]  cmd_op;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_mode;
  logic [1:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_err;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_err;

  // Environment side: issues commands, models the Alu, consumes responses.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_mode, alu_op,
    output alu_res, alu_err,
    input  rsp_valid, rsp_res, rsp_err,
    output rsp_ready
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_mode, alu_op,
    input  alu_res, alu_err,
    output rsp_valid, rsp_res, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 16-bit Alu: command FIFO, fixed-latency
// wait, held response with valid/ready, saturating op/error counters.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_errs
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_FW = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [1:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  cmd_t              mem [DEPTH];
  cmd_t              incoming;
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count;
  logic [CNT_FW-1:0] count_next;
  logic              full;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  cmd_t              alu_q;
  cmd_t              alu_next;
  logic              rsp_valid_q;
  logic              rsp_valid_next;
  logic [31:0]       rsp_res_q;
  logic [31:0]       rsp_res_next;
  logic              rsp_err_q;
  logic              rsp_err_next;
  logic [CNT_W-1:0]  ops_next;
  logic [CNT_W-1:0]  errs_next;
  logic              busy_next;

  assign incoming      = {bus.cmd_a, bus.cmd_b, bus.cmd_mode, bus.cmd_op};
  assign head          = mem[rd_ptr];
  assign full          = (count == CNT_FW'(DEPTH));
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;

  assign bus.alu_a     = alu_q.a;
  assign bus.alu_b     = alu_q.b;
  assign bus.alu_mode  = alu_q.mode;
  assign bus.alu_op    = alu_q.op;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_err   = rsp_err_q;

  // FIFO payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= incoming;
    end
  end

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_FW'(1);
      2'b01:   count_next = count - CNT_FW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Sequencing: pop/issue, count down the Alu latency, capture, hand off.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    wait_next      = wait_cnt;
    alu_next       = alu_q;
    rsp_valid_next = rsp_valid_q;
    rsp_res_next   = rsp_res_q;
    rsp_err_next   = rsp_err_q;
    ops_next       = stat_ops;
    errs_next      = stat_errs;

    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          alu_next   = head;
          wait_next  = WAIT_W'(LAT - 1);
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_cnt == '0) begin
          rsp_res_next   = bus.alu_res;
          rsp_err_next   = bus.alu_err;
          rsp_valid_next = 1'b1;
          state_next     = S_RESP;
        end else begin
          wait_next = wait_cnt - WAIT_W'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          if (stat_ops != '1) begin
            ops_next = stat_ops + CNT_W'(1);
          end
          if (rsp_err_q && (stat_errs != '1)) begin
            errs_next = stat_errs + CNT_W'(1);
          end
          if (count != '0) begin
            pop        = 1'b1;
            alu_next   = head;
            wait_next  = WAIT_W'(LAT - 1);
            state_next = S_WAIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE) || (count_next != '0);
  end

  // Controller state, Alu drive, response and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      alu_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      stat_ops    <= '0;
      stat_errs   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      alu_q       <= alu_next;
      rsp_valid_q <= rsp_valid_next;
      rsp_res_q   <= rsp_res_next;
      rsp_err_q   <= rsp_err_next;
      stat_ops    <= ops_next;
      stat_errs   <= errs_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed timing scenarios plus a
// randomized run scored against an in-order response queue.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();
  alu_issue_ctrl_if sbus();

  logic             busy;
  logic [CNT_W-1:0] stat_ops;
  logic [CNT_W-1:0] stat_errs;
  logic             s_busy;
  logic [SAT_W-1:0] s_ops;
  logic [SAT_W-1:0] s_errs;

  alu_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .stat_ops(stat_ops), .stat_errs(stat_errs)
  );

  alu_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus), .busy(s_busy), .stat_ops(s_ops), .stat_errs(s_errs)
  );

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  int exp_errs = 0;
  logic [32:0] exp_q[$];

  // Reference Alu behaviour: {err, res}.
  function automatic logic [32:0] alu_fn(input logic mode, input logic [1:0] op,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ax;
    logic [31:0] bx;
    ax = {16'h0, a};
    bx = {16'h0, b};
    if (!mode) begin
      case (op)
        2'd0:    return {1'b0, ax & bx};
        2'd1:    return {1'b0, ax | bx};
        2'd2:    return {1'b0, ax ^ bx};
        default: return {1'b0, 16'h0, ~a};
      endcase
    end else begin
      case (op)
        2'd0:    return {1'b0, ax + bx};
        2'd1:    return {1'b0, ax - bx};
        2'd2:    return {1'b0, ax * bx};
        default: return (b == 16'h0) ? {1'b1, 32'h0} : {1'b0, ax / bx};
      endcase
    end
  endfunction

  // Bench Alu with LAT=2: one register stage after the alu_* update edge.
  always @(posedge clk) begin
    {bus.alu_err, bus.alu_res}   <= alu_fn(bus.alu_mode, bus.alu_op, bus.alu_a, bus.alu_b);
    {sbus.alu_err, sbus.alu_res} <= alu_fn(sbus.alu_mode, sbus.alu_op, sbus.alu_a, sbus.alu_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic [1:0] o);
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_mode  = m;
    bus.cmd_op    = o;
  endtask

  task automatic rand_cmd(output logic [15:0] a, output logic [15:0] b,
                          output logic m, output logic [1:0] o);
    a = 16'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    m = 1'($urandom);
    o = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cmd(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
    bus.rsp_ready  = 1'b0;
    sbus.cmd_valid = 1'b0;
    sbus.cmd_a     = 16'h0;
    sbus.cmd_b     = 16'h0;
    sbus.cmd_mode  = 1'b0;
    sbus.cmd_op    = 2'd0;
    sbus.rsp_ready = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", bus.rsp_valid, busy); end
    checks++;
    if (stat_ops !== '0 || stat_errs !== '0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_ops, stat_errs); end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_op} !== 35'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_op}); end
    checks++;
    if ({bus.rsp_res, bus.rsp_err} !== 33'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_res, bus.rsp_err}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b0;
    set_cmd(1'b1, 16'h00F0, 16'h0FF0, 1'b0, 2'd0);
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.alu_a !== 16'h0) begin errors++; $display("FAIL single_alu_early: got %h want 0", bus.alu_a); end
    step();
    checks++;
    if (bus.alu_a !== 16'h00F0 || bus.alu_b !== 16'h0FF0) begin errors++; $display("FAIL single_alu_load: got %h/%h want 00f0/0ff0", bus.alu_a, bus.alu_b); end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", bus.rsp_valid); end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'h000000F0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got v=%b res=%h err=%b want v=1 res=000000f0 err=0", bus.rsp_valid, bus.rsp_res, bus.rsp_err);
    end
    repeat (3) step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'h000000F0) begin errors++; $display("FAIL single_hold: got v=%b res=%h want 1/000000f0", bus.rsp_valid, bus.rsp_res); end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_ops = 1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || stat_ops !== CNT_W'(exp_ops) || stat_errs !== '0) begin
      errors++; $display("FAIL single_done: got v=%b busy=%b ops=%0d errs=%0d want 0/0/%0d/0", bus.rsp_valid, busy, stat_ops, stat_errs, exp_ops);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic        m;
    logic [1:0]  o;
    logic [32:0] e;
    int          vcyc[$];
    int          got = 0;
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (cyc < 4) begin
        rand_cmd(a, b, m, o);
        set_cmd(1'b1, a, b, m, o);
        exp_q.push_back(alu_fn(m, o, a, b));
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cmd_ready: got %b want 1", bus.cmd_ready); end
      end else begin
        bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        checks++;
        if ({bus.rsp_err, bus.rsp_res} !== e) begin errors++; $display("FAIL b2b_rsp: got %h want %h", {bus.rsp_err, bus.rsp_res}, e); end
        exp_ops++;
        if (e[32]) exp_errs++;
        vcyc.push_back(cyc);
        got++;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    checks++;
    if (vcyc.size() > 0 && vcyc[0] != int'(LAT) + 2) begin errors++; $display("FAIL b2b_first: got %0d want %0d", vcyc[0], LAT + 2); end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++;
      if (vcyc[i] - vcyc[i-1] != int'(LAT) + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", vcyc[i] - vcyc[i-1], LAT + 1); end
    end
    checks++;
    if (busy !== 1'b0 || stat_ops !== CNT_W'(exp_ops)) begin errors++; $display("FAIL b2b_done: got busy=%b ops=%0d want 0/%0d", busy, stat_ops, exp_ops); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ca[6], cb[6];
    logic        cm[6];
    logic [1:0]  co[6];
    logic [32:0] e;
    int          acc = 0;
    int          got = 0;
    int          n = 0;
    logic        pushed5 = 1'b0;
    for (int i = 0; i < 6; i++) rand_cmd(ca[i], cb[i], cm[i], co[i]);
    bus.rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
      set_cmd(1'b1, ca[acc], cb[acc], cm[acc], co[acc]);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready: got %b want 1 at %0d queued", bus.cmd_ready, acc); end
      else begin exp_q.push_back(alu_fn(cm[acc], co[acc], ca[acc], cb[acc])); acc++; end
      step();
    end
    set_cmd(1'b1, ca[5], cb[5], cm[5], co[5]);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", bus.cmd_ready); end
    while (bus.rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || {bus.rsp_err, bus.rsp_res} !== exp_q[0]) begin
        errors++; $display("FAIL bp_hold: got ready=%b v=%b rsp=%h want 0/1/%h", bus.cmd_ready, bus.rsp_valid, {bus.rsp_err, bus.rsp_res}, exp_q[0]);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (!pushed5 && bus.cmd_ready === 1'b1) begin
        exp_q.push_back(alu_fn(cm[5], co[5], ca[5], cb[5]));
        pushed5 = 1'b1;
      end
      if (bus.rsp_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        checks++;
        if ({bus.rsp_err, bus.rsp_res} !== e) begin errors++; $display("FAIL bp_drain: got %h want %h", {bus.rsp_err, bus.rsp_res}, e); end
        exp_ops++;
        if (e[32]) exp_errs++;
        got++;
      end
      step();
      if (pushed5) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (got != 6 || stat_ops !== CNT_W'(exp_ops) || stat_errs !== CNT_W'(exp_errs)) begin
      errors++; $display("FAIL bp_done: got n=%0d ops=%0d errs=%0d want 6/%0d/%0d", got, stat_ops, stat_errs, exp_ops, exp_errs);
    end
  endtask

  task automatic test_error();
    logic [15:0] a, b;
    logic [32:0] e;
    int          n;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 16'($urandom);
      b = (i == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      set_cmd(1'b1, a, b, 1'b1, (i == 0) ? 2'd3 : 2'd0);
      e = alu_fn(1'b1, (i == 0) ? 2'd3 : 2'd0, a, b);
      step();
      bus.cmd_valid = 1'b0;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== (i == 0) || bus.rsp_res !== e[31:0]) begin
        errors++; $display("FAIL err_rsp%0d: got v=%b err=%b res=%h want 1/%0d/%h", i, bus.rsp_valid, bus.rsp_err, bus.rsp_res, (i == 0), e[31:0]);
      end
      step();
      exp_ops++;
      if (i == 0) exp_errs++;
      checks++;
      if (stat_errs !== CNT_W'(exp_errs) || stat_ops !== CNT_W'(exp_ops)) begin
        errors++; $display("FAIL err_stats%0d: got ops=%0d errs=%0d want %0d/%0d", i, stat_ops, stat_errs, exp_ops, exp_errs);
      end
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 60;
    logic [15:0] a, b;
    logic        m;
    logic [1:0]  o;
    logic [32:0] cur, e, hv;
    logic        held = 1'b0;
    logic        acc;
    int          sent = 0;
    int          got = 0;
    cur = '0;
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
      if (held) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_err, bus.rsp_res} !== hv) begin
          errors++; $display("FAIL rnd_hold: got v=%b rsp=%h want 1/%h", bus.rsp_valid, {bus.rsp_err, bus.rsp_res}, hv);
        end
      end
      if (bus.cmd_valid !== 1'b1 && sent < N && $urandom_range(0, 2) != 0) begin
        rand_cmd(a, b, m, o);
        set_cmd(1'b1, a, b, m, o);
        cur = alu_fn(m, o, a, b);
      end
      acc = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1);
      if (acc) begin exp_q.push_back(cur); sent++; end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      held = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        if (bus.rsp_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
          checks++;
          if ({bus.rsp_err, bus.rsp_res} !== e) begin errors++; $display("FAIL rnd_rsp: got %h want %h", {bus.rsp_err, bus.rsp_res}, e); end
          exp_ops++;
          if (e[32]) exp_errs++;
          got++;
        end else begin
          held = 1'b1;
          hv = {bus.rsp_err, bus.rsp_res};
        end
      end
      step();
      if (acc) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (got != N || busy !== 1'b0) begin errors++; $display("FAIL rnd_count: got n=%0d busy=%b want %0d/0", got, busy, N); end
    checks++;
    if (stat_ops !== CNT_W'(exp_ops) || stat_errs !== CNT_W'(exp_errs)) begin
      errors++; $display("FAIL rnd_stats: got ops=%0d errs=%0d want %0d/%0d", stat_ops, stat_errs, exp_ops, exp_errs);
    end
  endtask

  task automatic test_reset_wait();
    logic [15:0] a, b;
    logic        m;
    logic [1:0]  o;
    logic        seen = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(a, b, m, o);
      set_cmd(1'b1, a | 16'h1, b, m, o);
      step();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_pre: got busy=%b v=%b want 1/0", busy, bus.rsp_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_ctrl: got v=%b busy=%b ready=%b want 0/0/1", bus.rsp_valid, busy, bus.cmd_ready);
    end
    checks++;
    if (stat_ops !== '0 || stat_errs !== '0) begin errors++; $display("FAIL rstw_stats: got %0d/%0d want 0/0", stat_ops, stat_errs); end
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_mode !== 1'b0 || bus.alu_op !== 2'd0) begin
      errors++; $display("FAIL rstw_alu: got %h/%h/%b/%0d want 0", bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_op);
    end
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_ops = 0;
    exp_errs = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL rstw_dropped: got activity after reset want none"); end
  endtask

  task automatic test_saturation();
    int n;
    int sat_max;
    int exp_sat;
    sat_max = (1 << SAT_W) - 1;
    sbus.rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sbus.cmd_valid = 1'b1;
      sbus.cmd_a     = 16'($urandom);
      sbus.cmd_b     = 16'h0;
      sbus.cmd_mode  = 1'b1;
      sbus.cmd_op    = 2'd3;
      step();
      sbus.cmd_valid = 1'b0;
      n = 0;
      while (sbus.rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (sbus.rsp_valid !== 1'b1 || sbus.rsp_err !== 1'b1) begin errors++; $display("FAIL sat_rsp%0d: got v=%b err=%b want 1/1", i, sbus.rsp_valid, sbus.rsp_err); end
      step();
      exp_sat = (i > sat_max) ? sat_max : i;
      checks++;
      if (s_ops !== SAT_W'(exp_sat) || s_errs !== SAT_W'(exp_sat)) begin
        errors++; $display("FAIL sat_count%0d: got ops=%0d errs=%0d want %0d/%0d", i, s_ops, s_errs, exp_sat, exp_sat);
      end
    end
    sbus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_error();
    test_random();
    test_reset_wait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue controller directly upstream of the 16-bit Alu. It accepts operation commands (a, b, mode, op) over a valid/ready handshake and buffers them in a small FIFO. It drives the Alu operand/control inputs from registers, waits a fixed Alu latency, then captures res/err. The captured result is presented downstream on a valid/ready response port, with saturating operation and error counters.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
LAT, 2, Clock edges from alu_* update to alu_res/alu_err being valid; 1..15
CNT_W, 16, width of stat_ops and stat_errs

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  16  operand A
cmd_b  input  16  operand B
cmd_mode  input  1  0 = boolean, 1 = integer
cmd_op  input  2  operation select within mode
alu_a  output  16  registered operand A to Alu
alu_b  output  16  registered operand B to Alu
alu_mode  output  1  registered mode to Alu
alu_op  output  2  registered op to Alu
alu_res  input  32  Alu result
alu_err  input  1  Alu error flag
rsp_valid  output  1  response held
rsp_ready  input  1  downstream accepts response
rsp_res  output  32  captured result
rsp_err  output  1  captured error
busy  output  1  FIFO non-empty or state != IDLE
stat_ops  output  CNT_W  completed responses, saturating
stat_errs  output  CNT_W  completed responses with rsp_err=1, saturating

Behaviour:
- Reset (async, any time): FIFO emptied, state IDLE, all outputs 0 except cmd_ready=1; any in-flight command is discarded, with no response.
- Push: cmd_valid & cmd_ready at an edge writes {a,b,mode,op} to the FIFO. cmd_ready = !full; it is combinational on FIFO count only.
- Full: cmd_ready=0 even if a pop happens in the same cycle. A push on full cannot occur.
- No FIFO bypass. Pop happens only in IDLE with FIFO non-empty, or in RESP on handshake with FIFO non-empty.
- FSM states:
  - IDLE: when FIFO is non-empty, pop; load alu_* from the head; set wait_cnt=LAT-1; go to WAIT.
  - WAIT: if wait_cnt==0, capture alu_res->rsp_res and alu_err->rsp_err; set rsp_valid=1; go to RESP. Otherwise decrement wait_cnt.
  - RESP: rsp_* held stable while rsp_valid & !rsp_ready. On handshake:
    - rsp_valid=0.
    - stat_ops += 1, saturating at 2^CNT_W-1.
    - stat_errs += rsp_err, also saturating.
    - If FIFO is non-empty, pop, reload alu_*, set wait_cnt=LAT-1, go to WAIT (back-to-back). Otherwise go to IDLE.
- alu_* hold their last value in IDLE and RESP; they change only on pop.
- Timing: a command accepted into an empty FIFO at idle edge t0 updates alu_* at t0+1 and is captured at t0+1+LAT. rsp_valid is visible after that edge. Best-case throughput is one command per LAT+1 edges.
- FIFO order is strict first-in first-out. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- A push and a pop in the same edge (FIFO not full) leave the count unchanged.
- mode/op/operands are passed unmodified; no decoding. err is sourced only from the Alu.

Test Plan:
- Single command, LAT=2: a=0x00F0, b=0x0FF0, mode=0, op=0 accepted at t0. Required: alu_a/alu_b change at t0+1; rsp_valid after t0+3; rsp_res = bench-Alu value 0x000000F0; rsp_err=0; stat_ops=1.
- Back-to-back, rsp_ready tied high: 4 commands pushed on consecutive edges. Required: responses in push order, one every LAT+1 edges, with no gaps. busy falls 1 edge after the last handshake.
- Backpressure, rsp_ready=0: push 6 commands. Required: cmd_ready low once 4 are queued plus 1 in flight. rsp_res stable throughout. Releasing rsp_ready drains all 6 in order.
- Error path: the bench Alu asserts alu_err for mode=1, op=3, b=0. Required: rsp_err=1 and stat_errs increments. A following normal command gives rsp_err=0 and stat_errs unchanged.
- Reset during WAIT: pulse Reset mid-wait, asynchronously between edges. Required: immediate rsp_valid=0, busy=0, cmd_ready=1, counters=0, alu_*=0; no response for the dropped command.
- Saturation with CNT_W=2: complete 5 error responses. Required: stat_ops=3 and stat_errs=3, with no wrap.
